latch_mem_stream: RTL and testbench

Parametrised successor to the single-port 64x8 latch memory tile: DEPTH x WIDTH flop-based storage with a registered read port. Adds a post-reset clear sweep, a read-valid strobe, and an auto-increment streaming mode with an internal wrapping address pointer. Sits directly behind the tile's ui/uio pin mapping, so the host can burst-load or burst-dump memory without driving an address every cycle.

---
 rtl/latch_mem_stream.sv | 194 +++++++++++++++++++
 tb/tb_latch_mem_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_mem_stream.sv
// ============================================================================
// Module      : latch_mem_stream
// Description : DEPTH x WIDTH flop-based memory with a registered read port,
//               a post-reset clear sweep, a read-valid strobe and an
//               auto-increment streaming pointer that wraps DEPTH-1 -> 0.
//               Optional feature macro: PARITY_EN (per-word even parity with
//               fault injection on write and error flag on read).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module latch_mem_stream #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              auto_inc,
    input  logic              ptr_load,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              par_inject,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrap,
    output logic              busy,
    output logic              par_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] C_ST_CLEAR = 1'b0;
    localparam logic [0:0] C_ST_IDLE  = 1'b1;

    localparam logic [ADDR_W-1:0] C_LAST      = ADDR_W'(DEPTH - 1);
    // One bit wider than an address so DEPTH itself is representable
    localparam logic [ADDR_W:0]   C_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

`ifdef PARITY_EN
    localparam int C_MEM_W = WIDTH + 1;
`else
    localparam int C_MEM_W = WIDTH;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [C_MEM_W-1:0] r_mem [DEPTH];

    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_cnt;
    logic               r_busy;
    logic [ADDR_W-1:0]  r_ptr;
    logic               r_wrap;
    logic               r_rd_valid;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_par_err;

    // ------------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------------
    logic               w_idle;
    logic [ADDR_W-1:0]  w_acc_addr;
    logic               w_in_range;
    logic               w_load_in_range;
    logic               w_acc_last;
    logic               w_do_wr;
    logic               w_any_req;
    logic [ADDR_W-1:0]  w_ptr_next_acc;
    logic [C_MEM_W-1:0] w_rd_word;
    logic [C_MEM_W-1:0] w_wr_word;
    logic [WIDTH-1:0]   w_rd_data;
    logic               w_rd_perr;

    assign w_idle = (r_state == C_ST_IDLE);

    // A pointer load in the same cycle redirects the access to addr, so a
    // stream can be (re)started and its first beat issued in one cycle.
    assign w_acc_addr = (auto_inc && !ptr_load) ? r_ptr : addr;

    // Only reachable with a non-power-of-2 DEPTH; constant true otherwise.
    assign w_in_range      = ({1'b0, w_acc_addr} < C_DEPTH_EXT);
    assign w_load_in_range = ({1'b0, addr} < C_DEPTH_EXT);

    assign w_acc_last = (w_acc_addr == C_LAST);
    assign w_any_req  = rd_en | wr_en;
    assign w_do_wr    = w_idle & wr_en & w_in_range;

    // An out-of-range access in auto mode restarts the stream at word 0.
    assign w_ptr_next_acc = (!w_in_range || w_acc_last) ? '0
                                                        : w_acc_addr + ADDR_W'(1);

    // Out-of-range reads return zero rather than whatever the index aliases to
    assign w_rd_word = w_in_range ? r_mem[w_acc_addr] : '0;
    assign w_rd_data = w_rd_word[WIDTH-1:0];

`ifdef PARITY_EN
    // Stored bit makes the word even parity; par_inject deliberately breaks it
    assign w_wr_word = {(^data_in) ^ par_inject, data_in};
    assign w_rd_perr = w_in_range && (w_rd_word[WIDTH] != (^w_rd_word[WIDTH-1:0]));
`else
    logic w_unused_par_inject;
    assign w_unused_par_inject = par_inject;
    assign w_wr_word = data_in;
    assign w_rd_perr = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Storage: zeroed word by word during the clear sweep, written when idle
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == C_ST_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (w_do_wr) begin
                r_mem[w_acc_addr] <= w_wr_word;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM: clear sweep after reset, then serve read/write/pointer ops
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_ST_CLEAR;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_ptr      <= '0;
            r_wrap     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_data_out <= '0;
            r_par_err  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below
            r_wrap     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_par_err  <= 1'b0;

            case (r_state)
                C_ST_CLEAR: begin
                    if (r_cnt == C_LAST) begin
                        r_state <= C_ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end

                C_ST_IDLE: begin
                    // Read sees pre-write contents when both are requested
                    if (rd_en) begin
                        r_data_out <= w_rd_data;
                        r_rd_valid <= 1'b1;
                        r_par_err  <= w_rd_perr;
                    end

                    // One pointer step per accepted access, even for rd+wr
                    if (auto_inc && w_any_req) begin
                        r_ptr  <= w_ptr_next_acc;
                        r_wrap <= w_in_range && w_acc_last;
                    end else if (ptr_load) begin
                        r_ptr <= w_load_in_range ? addr : '0;
                    end
                end

                default: begin
                    r_state <= C_ST_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign ptr      = r_ptr;
    assign wrap     = r_wrap;
    assign busy     = r_busy;
    assign par_err  = r_par_err;

endmodule

`default_nettype wire

// File: tb/tb_latch_mem_stream.sv
// ============================================================================
// Module      : tb_latch_mem_stream
// Description : Self-checking bench for latch_mem_stream: directed vector
//               table, hand-written reset/clear and parity sequences, and a
//               randomized phase compared against a behavioural model.
//               Honours PARITY_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_latch_mem_stream;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              rd_en;
    logic              auto_inc;
    logic              ptr_load;
    logic [WIDTH-1:0]  data_in;
    logic              par_inject;
    logic [WIDTH-1:0]  data_out;
    logic              rd_valid;
    logic [ADDR_W-1:0] ptr;
    logic              wrap;
    logic              busy;
    logic              par_err;

    int n_checks = 0;
    int n_err    = 0;

    latch_mem_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .auto_inc   (auto_inc),
        .ptr_load   (ptr_load),
        .data_in    (data_in),
        .par_inject (par_inject),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .ptr        (ptr),
        .wrap       (wrap),
        .busy       (busy),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural reference: memory array, pointer, outputs of the last edge
    // ------------------------------------------------------------------------
    int m_mem [DEPTH];
    bit m_bad [DEPTH];
    int m_ptr;
    int m_dout;
    bit m_rv;
    bit m_wrap;
    bit m_perr;
    int m_busy_left;

    task automatic model_step();
        int a;
        if (rst) begin
            m_dout = 0; m_rv = 0; m_ptr = 0; m_wrap = 0; m_perr = 0;
            m_busy_left = DEPTH;
        end else if (m_busy_left > 0) begin
            m_mem[DEPTH - m_busy_left] = 0;
            m_bad[DEPTH - m_busy_left] = 0;
            m_busy_left = m_busy_left - 1;
            m_rv = 0; m_wrap = 0; m_perr = 0;
        end else begin
            a = (auto_inc && !ptr_load) ? m_ptr : int'(addr);
            m_rv = rd_en;
            m_perr = 0;
            m_wrap = 0;
            if (rd_en) begin
                m_dout = m_mem[a];
`ifdef PARITY_EN
                m_perr = m_bad[a];
`endif
            end
            if (wr_en) begin
                m_mem[a] = int'(data_in);
                m_bad[a] = par_inject;
            end
            if (auto_inc && (rd_en || wr_en)) begin
                m_wrap = (a == DEPTH - 1);
                m_ptr  = (a + 1) % DEPTH;
            end else if (ptr_load) begin
                m_ptr = int'(addr);
            end
        end
    endtask

    // Advance one clock; the model consumes the same inputs the DUT samples
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        addr = '0; wr_en = 0; rd_en = 0; auto_inc = 0; ptr_load = 0;
        data_in = '0; par_inject = 0;
    endtask

    task automatic check_vs_model(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
        check({tag, ".ptr"},      32'(ptr),      32'(m_ptr));
        check({tag, ".wrap"},     32'(wrap),     32'(m_wrap));
        check({tag, ".busy"},     32'(busy),     32'(m_busy_left > 0));
        check({tag, ".par_err"},  32'(par_err),  32'(m_perr));
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors applied after the first clear sweep
    // ------------------------------------------------------------------------
    typedef struct {
        bit               rd;
        bit               wr;
        bit               ai;
        bit               pl;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  din;
        logic [WIDTH-1:0]  e_dout;
        bit               e_rv;
        logic [ADDR_W-1:0] e_ptr;
        bit               e_wrap;
    } vec_t;

    localparam int NV = 20;
    vec_t vec [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int viol;

        //        rd    wr    ai    pl    addr    din     dout    rv    ptr     wrap
        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd5,  8'h00, 8'h00, 1'b1, 6'd0,  1'b0};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  8'h00, 8'h00, 1'b0, 6'd0,  1'b0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd18, 8'hA5, 8'h00, 1'b0, 6'd0,  1'b0};
        vec[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd18, 8'h00, 8'hA5, 1'b1, 6'd0,  1'b0};
        vec[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  8'h00, 8'hA5, 1'b0, 6'd0,  1'b0};
        vec[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd62, 8'h00, 8'hA5, 1'b0, 6'd62, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  8'h11, 8'hA5, 1'b0, 6'd63, 1'b0};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  8'h22, 8'hA5, 1'b0, 6'd0,  1'b1};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  8'h33, 8'hA5, 1'b0, 6'd1,  1'b0};
        vec[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd62, 8'h00, 8'h11, 1'b1, 6'd63, 1'b0};
        vec[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  8'h00, 8'h22, 1'b1, 6'd0,  1'b1};
        vec[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  8'h00, 8'h33, 1'b1, 6'd1,  1'b0};
        vec[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  8'h00, 8'h33, 1'b0, 6'd1,  1'b0};
        vec[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd7,  8'h3C, 8'h33, 1'b0, 6'd1,  1'b0};
        vec[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd7,  8'hC3, 8'h3C, 1'b1, 6'd1,  1'b0};
        vec[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd7,  8'h00, 8'hC3, 1'b1, 6'd1,  1'b0};
        vec[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd40, 8'h00, 8'hC3, 1'b0, 6'd40, 1'b0};
        vec[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd63, 8'h00, 8'h22, 1'b1, 6'd40, 1'b0};
        vec[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  8'h5A, 8'h00, 1'b1, 6'd41, 1'b0};
        vec[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd40, 8'h00, 8'h5A, 1'b1, 6'd41, 1'b0};

        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 0;
            m_bad[i] = 0;
        end
        m_ptr = 0; m_dout = 0; m_rv = 0; m_wrap = 0; m_perr = 0; m_busy_left = DEPTH;

        // ---------------- reset state and clear sweep length ----------------
        idle_inputs();
        rst = 1;
        tick();
        tick();
        check("reset.data_out", 32'(data_out), 32'h0);
        check("reset.rd_valid", 32'(rd_valid), 32'h0);
        check("reset.ptr",      32'(ptr),      32'h0);
        check("reset.wrap",     32'(wrap),     32'h0);
        check("reset.busy",     32'(busy),     32'h1);
        check("reset.par_err",  32'(par_err),  32'h0);

        rst = 0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        check("clear.busy_cycles", 32'(n), 32'd64);

        // ---------------- directed table ----------------
        for (int i = 0; i < NV; i++) begin
            rd_en = vec[i].rd; wr_en = vec[i].wr; auto_inc = vec[i].ai;
            ptr_load = vec[i].pl; addr = vec[i].addr; data_in = vec[i].din;
            par_inject = 0;
            tick();
            check($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vec[i].e_dout));
            check($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vec[i].e_rv));
            check($sformatf("vec%0d.ptr", i),      32'(ptr),      32'(vec[i].e_ptr));
            check($sformatf("vec%0d.wrap", i),     32'(wrap),     32'(vec[i].e_wrap));
            check($sformatf("vec%0d.par_err", i),  32'(par_err),  32'h0);
        end
        idle_inputs();
        tick();

        // ---------------- reset mid-sweep restarts the clear ----------------
        wr_en = 1; addr = 6'd3; data_in = 8'h55;
        tick();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        repeat (20) tick();
        check("sweep20.busy", 32'(busy), 32'h1);
        rst = 1;
        tick();
        rst = 0;
        // Requests held during the sweep must be ignored
        wr_en = 1; rd_en = 1; ptr_load = 1; auto_inc = 1; addr = 6'd9; data_in = 8'hFF;
        n = 0;
        viol = 0;
        while (busy && n < 200) begin
            n++;
            tick();
            if (rd_valid || ptr != 0 || wrap) viol++;
        end
        idle_inputs();
        check("restart.busy_cycles", 32'(n), 32'd64);
        check("restart.ignored_requests", 32'(viol), 32'd0);
        rd_en = 1; addr = 6'd3;
        tick();
        check("restart.word3.data_out", 32'(data_out), 32'h0);
        check("restart.word3.rd_valid", 32'(rd_valid), 32'h1);
        rd_en = 1; addr = 6'd9;
        tick();
        check("restart.word9.data_out", 32'(data_out), 32'h0);
        idle_inputs();
        tick();

        // ---------------- parity injection ----------------
        wr_en = 1; addr = 6'd9; data_in = 8'h01; par_inject = 1;
        tick();
        idle_inputs();
        rd_en = 1; addr = 6'd9;
        tick();
        check("par_inj.data_out", 32'(data_out), 32'h01);
        check("par_inj.rd_valid", 32'(rd_valid), 32'h1);
`ifdef PARITY_EN
        check("par_inj.par_err",  32'(par_err),  32'h1);
`else
        check("par_inj.par_err",  32'(par_err),  32'h0);
`endif
        idle_inputs();
        tick();
        check("par_inj.par_err_drop", 32'(par_err), 32'h0);
        wr_en = 1; addr = 6'd9; data_in = 8'h01; par_inject = 0;
        tick();
        idle_inputs();
        rd_en = 1; addr = 6'd9;
        tick();
        check("par_ok.par_err", 32'(par_err), 32'h0);
        idle_inputs();
        tick();
        check_vs_model("sync");

        // ---------------- randomized phase vs reference model ----------------
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 399) == 0);
            rd_en      = ($urandom_range(0, 1) == 1);
            wr_en      = ($urandom_range(0, 1) == 1);
            auto_inc   = ($urandom_range(0, 2) != 0);
            ptr_load   = ($urandom_range(0, 7) == 0);
            addr       = ADDR_W'($urandom_range(0, DEPTH - 1));
            data_in    = WIDTH'($urandom);
            par_inject = ($urandom_range(0, 3) == 0);
            tick();
            check_vs_model($sformatf("rand%0d", c));
        end
        rst = 0;
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
